seq_mul_param: RTL and testbench

Parametrised sequential shift-add multiplier with a start/busy/finish handshake. It takes two WIDTH-bit operands and produces the full 2·WIDTH-bit product. A mode input selects unsigned or two's-complement signed operation per transaction. It is the general-purpose replacement for the fixed 32-bit sign-magnitude multiplier in the lab datapath, and sits behind the ALU/controller as a multi-cycle functional unit.

---
 rtl/seq_mul_param.sv | 77 +++++++
 tb/tb_seq_mul_param.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_mul_param.sv
// rtl/seq_mul_param.sv - shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, signed/unsigned
module seq_mul_param #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic [2*WIDTH-1:0] res,
  output logic               finish
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mag_a;
  logic [2*WIDTH:0] prod;
  logic             neg;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   upper;

  // Magnitudes fit in WIDTH unsigned bits, even for the most negative operand.
  always_comb begin
    a_abs = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_abs = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    upper = prod[2*WIDTH:WIDTH] + (prod[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      finish <= 1'b0;
      res    <= '0;
      mag_a  <= '0;
      prod   <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            busy  <= 1'b1;
            mag_a <= a_abs;
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt   <= '0;
            prod  <= {{(WIDTH+1){1'b0}}, b_abs};
          end
        end
        CALC: begin
          // Add-then-shift; the carry lands in the top bit before shifting down.
          prod <= {1'b0, upper, prod[WIDTH-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          res    <= neg ? (~prod[2*WIDTH-1:0] + (2*WIDTH)'(1)) : prod[2*WIDTH-1:0];
          finish <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_param.sv
// tb/tb_seq_mul_param.sv - directed and random checks of seq_mul_param at WIDTH 32, 8 and 4
module tb_seq_mul_param;

  logic        clk = 1'b0;
  logic        rst;
  logic        sm;
  logic [63:0] op_a, op_b;
  logic        start32, start8, start4;
  logic        busy32, busy8, busy4;
  logic        fin32, fin8, fin4;
  logic [63:0] res32;
  logic [15:0] res8;
  logic [7:0]  res4;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  seq_mul_param #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .start(start32), .signed_mode(sm),
    .a(op_a[31:0]), .b(op_b[31:0]), .busy(busy32), .res(res32), .finish(fin32));
  seq_mul_param #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .start(start8), .signed_mode(sm),
    .a(op_a[7:0]), .b(op_b[7:0]), .busy(busy8), .res(res8), .finish(fin8));
  seq_mul_param #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .start(start4), .signed_mode(sm),
    .a(op_a[3:0]), .b(op_b[3:0]), .busy(busy4), .res(res4), .finish(fin4));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic fin_of(input int s);
    case (s)
      0: return fin32;
      1: return fin8;
      default: return fin4;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      0: return busy32;
      1: return busy8;
      default: return busy4;
    endcase
  endfunction

  function automatic logic [127:0] res_of(input int s);
    case (s)
      0: return {64'b0, res32};
      1: return {112'b0, res8};
      default: return {120'b0, res4};
    endcase
  endfunction

  task automatic mon(input int s);
    if (exp_q.size() == 0) chk($sformatf("spurious_finish_%0d", s), 128'(fin_of(s)), 128'(0));
    else chk($sformatf("res_%0d", s), res_of(s), exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (fin32) mon(0);
    if (fin8)  mon(1);
    if (fin4)  mon(2);
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input int s, input logic m, input logic [63:0] aa, input logic [63:0] bb,
                        input logic [127:0] exp, input bit push);
    sm = m; op_a = aa; op_b = bb;
    start32 = (s == 0); start8 = (s == 1); start4 = (s == 2);
    if (push) exp_q.push_back(exp);
    @(negedge clk);
    start32 = 1'b0; start8 = 1'b0; start4 = 1'b0;
    chk("busy_after_start", 128'(busy_of(s)), 128'(1));
  endtask

  // Counts edges from the accepting edge until finish is seen.
  task automatic wait_fin(input int s, input int w, input int n0, input bit hold_en,
                          input logic [127:0] hold);
    int n = n0;
    while (!fin_of(s) && n < w + 10) begin
      chk("busy_in_calc", 128'(busy_of(s)), 128'(1));
      if (hold_en) chk("res_hold", res_of(s), hold);
      @(negedge clk);
      n++;
    end
    chk("latency", 128'(n), 128'(w + 1));
    chk("busy_at_finish", 128'(busy_of(s)), 128'(0));
  endtask

  task automatic op(input int s, input int w, input logic m, input logic [63:0] aa,
                    input logic [63:0] bb, input logic [127:0] exp);
    launch(s, m, aa, bb, exp, 1'b1);
    wait_fin(s, w, 0, 1'b0, '0);
    @(negedge clk);
    chk("finish_one_cycle", 128'(fin_of(s)), 128'(0));
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rm;
    logic [15:0] rexp;
    bit          saw_fin;
    rst = 1'b1; sm = 1'b0; op_a = '0; op_b = '0;
    start32 = 1'b0; start8 = 1'b0; start4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {125'b0, busy32, busy8, busy4}, 128'(0));
    chk("reset_finish", {125'b0, fin32, fin8, fin4}, 128'(0));
    chk("reset_res", {res32, res8, res4, 40'b0}, 128'(0));
    rst = 1'b0;
    @(negedge clk);

    op(0, 32, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 128'hFFFFFFFE00000001);
    op(1, 8, 1'b1, 64'hFD, 64'h05, 128'hFFF1);
    op(1, 8, 1'b1, 64'h80, 64'h80, 128'h4000);
    op(1, 8, 1'b0, 64'h80, 64'h80, 128'h4000);
    op(1, 8, 1'b1, 64'h80, 64'h7F, 128'hC080);
    op(2, 4, 1'b0, 64'hF, 64'hF, 128'hE1);
    op(2, 4, 1'b1, 64'hF, 64'hF, 128'h01);
    op(2, 4, 1'b0, 64'h0, 64'hF, 128'h0);

    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rm = 1'($urandom);
      if (rm) rexp = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
      else    rexp = 16'({8'b0, ra} * {8'b0, rb});
      op(1, 8, rm, {56'b0, ra}, {56'b0, rb}, {112'b0, rexp});
    end

    // Start during CALC is ignored; then back-to-back start in the finish cycle.
    launch(1, 1'b0, 64'h12, 64'h34, 128'h03A8, 1'b1);
    repeat (3) @(negedge clk);
    sm = 1'b1; op_a = 64'hFF; op_b = 64'h7F; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_fin(1, 8, 4, 1'b0, '0);
    launch(1, 1'b0, 64'h0A, 64'h0B, 128'h6E, 1'b1);
    chk("finish_pulse_b2b", 128'(fin8), 128'(0));
    wait_fin(1, 8, 0, 1'b1, 128'h03A8);
    @(negedge clk);

    // Reset mid-CALC drops the transaction.
    launch(1, 1'b1, 64'hFD, 64'h05, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 128'(busy8), 128'(0));
    chk("rst_res", 128'(res8), 128'(0));
    saw_fin = 1'b0;
    repeat (15) begin
      if (fin8) saw_fin = 1'b1;
      @(negedge clk);
    end
    chk("rst_no_finish", 128'(saw_fin), 128'(0));
    op(1, 8, 1'b1, 64'h07, 64'hF9, 128'hFFCF);

    chk("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
